// File: rtl/npu_mult_pkg.sv
// npu_mult_pkg: shared state encoding and width helpers for the sequential multiplier
package npu_mult_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   function automatic int prod_w(input int aw, input int bw);
      return aw + bw;
   endfunction
   function automatic int cnt_w(input int bw);
      return $clog2(bw + 1);
   endfunction
endpackage

// File: rtl/npu_mult_mag.sv
// npu_mult_mag: sign/magnitude split of an optionally two's-complement value
module npu_mult_mag #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic         tc,
   output logic [W-1:0] mag,
   output logic         sign
);
   assign sign = tc & x[W-1];
   assign mag  = sign ? -x : x;
endmodule

// File: rtl/npu_mult_seq.sv
// npu_mult_seq: one-bit-per-cycle shift-add multiplier; NPU_MULT_SEQ_EARLY_EXIT_EN stops once the multiplier runs out of set bits
module npu_mult_seq
   import npu_mult_pkg::*;
#(
   parameter int A_WIDTH = 8,
   parameter int B_WIDTH = 8,
   parameter int CNT_W   = cnt_w(B_WIDTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [A_WIDTH-1:0]         a,
   input  logic [B_WIDTH-1:0]         b,
   input  logic                       tc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [A_WIDTH+B_WIDTH-1:0] product,
   output logic                       busy
);
   localparam int P = prod_w(A_WIDTH, B_WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(B_WIDTH - 1);
   state_t state;
   logic [A_WIDTH-1:0] mag_a, a_mag;
   logic [B_WIDTH-1:0] mag_b, b_mag;
   logic [P-1:0] acc, acc_next, fin;
   logic [P:0] res_mag;
   logic [CNT_W-1:0] cnt;
   logic neg, a_sign, b_sign, res_sign, accept, last;
   npu_mult_mag #(.W(A_WIDTH)) u_mag_a (.x(a), .tc(tc), .mag(a_mag), .sign(a_sign));
   npu_mult_mag #(.W(B_WIDTH)) u_mag_b (.x(b), .tc(tc), .mag(b_mag), .sign(b_sign));
   // Prepending neg as the MSB makes the magnitude unit negate exactly when the result is negative;
   // bit P of its output is set only for a negated zero, which is suppressed so -0 never appears.
   npu_mult_mag #(.W(P+1)) u_mag_res (.x({neg, acc_next}), .tc(1'b1), .mag(res_mag), .sign(res_sign));
   assign in_ready = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
   assign busy     = state != IDLE;
   assign accept   = in_valid & in_ready;
   assign acc_next = mag_b[0] ? acc + (P'(mag_a) << cnt) : acc;
   assign fin      = res_sign ? (res_mag[P] ? '0 : res_mag[P-1:0]) : acc_next;
`ifdef NPU_MULT_SEQ_EARLY_EXIT_EN
   assign last = (cnt == LAST) | ~|mag_b[B_WIDTH-1:1];
`else
   assign last = cnt == LAST;
`endif
   // Handshake FSM: accept operands, iterate one multiplier bit per cycle, hold the product until taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         product   <= '0;
         mag_a     <= '0;
         mag_b     <= '0;
         acc       <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
      end else if (accept) begin
         state     <= CALC;
         out_valid <= 1'b0;
         mag_a     <= a_mag;
         mag_b     <= b_mag;
         neg       <= a_sign ^ b_sign;
         acc       <= '0;
         cnt       <= '0;
      end else if (state == CALC) begin
         acc   <= acc_next;
         mag_b <= mag_b >> 1;
         cnt   <= cnt + 1'b1;
         if (last) begin
            product   <= fin;
            out_valid <= 1'b1;
            state     <= DONE;
         end
      end else if ((state == DONE) && out_ready) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_npu_mult_seq.sv
// tb_npu_mult_seq: directed-vector bench for npu_mult_seq (honours NPU_MULT_SEQ_EARLY_EXIT_EN for latency)
module tb_npu_mult_seq;
   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, in_ready, tc = 1'b0, out_valid, out_ready = 1'b0, busy;
   logic [7:0] a = '0, b = '0;
   logic [15:0] product;
   int n_chk = 0, n_pass = 0;

   npu_mult_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .tc(tc), .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic int exp_lat(input logic [7:0] bv, input logic tcv);
`ifdef NPU_MULT_SEQ_EARLY_EXIT_EN
      logic [7:0] m;
      int l;
      m = (tcv & bv[7]) ? 8'(-bv) : bv;
      l = 1;
      for (int i = 0; i < 8; i++) if (m[i]) l = i + 1;
      return l;
`else
      return 8;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag, input logic [7:0] bv, input logic tcv);
      int cyc;
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      chk({tag, " latency"}, cyc, exp_lat(bv, tcv));
   endtask

   task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic tcv,
                         input logic [15:0] exp);
      chk({tag, " in_ready"}, in_ready, 1'b1);
      in_valid = 1'b1; a = av; b = bv; tc = tcv;
      tick();
      in_valid = 1'b0; a = ~av; b = ~bv; tc = ~tcv;
      wait_done(tag, bv, tcv);
      chk({tag, " product"}, product, exp);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " drain"}, {out_valid, busy}, 2'b00);
   endtask

   initial begin
      int hi;
      #2;
      chk("rst in_ready", in_ready, 1'b0);
      chk("rst outputs", {out_valid, busy, product}, 18'h0);
      tick();
      rst = 1'b0;
      #1;
      chk("post-rst in_ready", in_ready, 1'b1);
      // abort an operation by reset mid-CALC
      in_valid = 1'b1; a = 8'h05; b = 8'h03; tc = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("mid calc busy", {busy, in_ready}, 2'b10);
      rst = 1'b1;
      #1;
      chk("abort rst state", {in_ready, out_valid, busy, product}, 19'h0);
      tick();
      rst = 1'b0;
      #1;
      chk("abort release in_ready", in_ready, 1'b1);
      hi = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) hi++;
      end
      chk("abort no output", hi, 0);
      chk("abort product", product, 16'h0);
      run_op("u ff*ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
      run_op("s fd*07", 8'hFD, 8'h07, 1'b1, 16'hFFEB);
      run_op("s 80*80", 8'h80, 8'h80, 1'b1, 16'h4000);
      run_op("s 00*ff", 8'h00, 8'hFF, 1'b1, 16'h0000);
      run_op("s 7f*81", 8'h7F, 8'h81, 1'b1, 16'hC0FF);
      run_op("s 80*7f", 8'h80, 8'h7F, 1'b1, 16'hC080);
      run_op("s ff*ff", 8'hFF, 8'hFF, 1'b1, 16'h0001);
      run_op("u 05*03", 8'h05, 8'h03, 1'b0, 16'h000F);
      run_op("u 01*01", 8'h01, 8'h01, 1'b0, 16'h0001);
      run_op("u 03*10", 8'h03, 8'h10, 1'b0, 16'h0030);
      run_op("u 03*80", 8'h03, 8'h80, 1'b0, 16'h0180);
      run_op("u 0a*00", 8'h0A, 8'h00, 1'b0, 16'h0000);
      // backpressure followed by a same-edge back-to-back acceptance
      in_valid = 1'b1; a = 8'hFF; b = 8'hFF; tc = 1'b0;
      tick();
      in_valid = 1'b0;
      wait_done("bp first", 8'hFF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("bp hold", {out_valid, in_ready, busy, product}, {3'b101, 16'hFE01});
         tick();
      end
      out_ready = 1'b1; in_valid = 1'b1; a = 8'h02; b = 8'h03; tc = 1'b0;
      #1;
      chk("b2b in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0; out_ready = 1'b0; a = 8'h77; b = 8'h55;
      chk("b2b accepted", {out_valid, busy, in_ready}, 3'b010);
      wait_done("b2b", 8'h03, 1'b0);
      chk("b2b product", product, 16'h0006);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("b2b drain", {out_valid, busy, in_ready}, 3'b001);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
